// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: fetch, load/store and byte-wide RAM signals of mem_ctrl.
// slave = controller side; master = pipeline stages plus the RAM.
//
// Fetch  : if_req_i, if_addr_i, if_flush_i -> if_done_o, if_inst_o
// Ld/St  : mem_req_i, mem_we_i, mem_addr_i, mem_len_i, mem_wdata_i
//          -> mem_done_o, mem_rdata_o
// RAM    : ram_din_i -> ram_dout_o, ram_a_o, ram_wr_o
// Status : busy_o
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_flush_i;
    logic                  if_done_o;
    logic [31:0]           if_inst_o;
    logic                  mem_req_i;
    logic                  mem_we_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [1:0]            mem_len_i;
    logic [31:0]           mem_wdata_i;
    logic                  mem_done_o;
    logic [31:0]           mem_rdata_o;
    logic [7:0]            ram_din_i;
    logic [7:0]            ram_dout_o;
    logic [ADDR_WIDTH-1:0] ram_a_o;
    logic                  ram_wr_o;
    logic                  busy_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  mem_req_i, mem_we_i, mem_addr_i,
        input  mem_len_i, mem_wdata_i, ram_din_i,
        output if_done_o, if_inst_o,
        output mem_done_o, mem_rdata_o,
        output ram_dout_o, ram_a_o, ram_wr_o, busy_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output mem_req_i, mem_we_i, mem_addr_i,
        output mem_len_i, mem_wdata_i, ram_din_i,
        input  if_done_o, if_inst_o,
        input  mem_done_o, mem_rdata_o,
        input  ram_dout_o, ram_a_o, ram_wr_o, busy_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial single-port RAM controller shared by fetch and MEM.
// Ports: clk, rst (sync, active-high), bus (mem_ctrl_if.slave).
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic [7:0]            ram_dout_q, ram_dout_d;
    logic                  ram_wr_q, ram_wr_d;
    logic                  if_done_q, if_done_d;
    logic [31:0]           if_inst_q, if_inst_d;
    logic                  mem_done_q, mem_done_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;
    logic                  busy_q, busy_d;

    // k is the index of the edge being evaluated, counted from accept.
    logic [2:0]            k;
    logic [ADDR_WIDTH-1:0] addr_k;
    logic [31:0]           buf_ins;
    logic [2:0]            mem_n;

    assign k      = cnt_q + 3'd1;
    assign addr_k = base_q + ADDR_WIDTH'(k);

    always_comb begin
        mem_n = 3'd4;
        if (bus.mem_len_i == 2'b00) mem_n = 3'd1;
        if (bus.mem_len_i == 2'b01) mem_n = 3'd2;
    end

    // Byte k-2 arrives on ram_din_i at edge k (one address, one RAM stage).
    always_comb begin
        buf_ins = buf_q;
        case (cnt_q)
            3'd1:    buf_ins[7:0]   = bus.ram_din_i;
            3'd2:    buf_ins[15:8]  = bus.ram_din_i;
            3'd3:    buf_ins[23:16] = bus.ram_din_i;
            3'd4:    buf_ins[31:24] = bus.ram_din_i;
            default: buf_ins = buf_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        if_inst_d   = if_inst_q;
        mem_done_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                // A done pulse in flight forces one bubble cycle.
                if (!if_done_q && !mem_done_q) begin
                    if (bus.mem_req_i) begin
                        base_d  = bus.mem_addr_i;
                        len_d   = mem_n;
                        cnt_d   = 3'd0;
                        buf_d   = 32'd0;
                        wdata_d = bus.mem_wdata_i;
                        ram_a_d = bus.mem_addr_i;
                        if (bus.mem_we_i) begin
                            state_d    = MEM_WR;
                            ram_dout_d = bus.mem_wdata_i[7:0];
                            ram_wr_d   = 1'b1;
                        end else begin
                            state_d = MEM_RD;
                        end
                    end else if (bus.if_req_i && !bus.if_flush_i) begin
                        state_d = IF_RD;
                        base_d  = bus.if_addr_i;
                        len_d   = 3'd4;
                        cnt_d   = 3'd0;
                        buf_d   = 32'd0;
                        ram_a_d = bus.if_addr_i;
                    end
                end
            end
            IF_RD, MEM_RD: begin
                if (state_q == IF_RD && bus.if_flush_i) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = k;
                    if (k < len_q) ram_a_d = addr_k;
                    if (k >= 3'd2) buf_d = buf_ins;
                    if (k == len_q + 3'd1) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                        if (state_q == IF_RD) begin
                            if_inst_d = buf_ins;
                            if_done_d = 1'b1;
                        end else begin
                            mem_rdata_d = buf_ins;
                            mem_done_d  = 1'b1;
                        end
                    end
                end
            end
            MEM_WR: begin
                cnt_d = k;
                if (k < len_q) begin
                    ram_a_d    = addr_k;
                    ram_dout_d = wdata_q[{k[1:0], 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                end else begin
                    state_d    = IDLE;
                    cnt_d      = 3'd0;
                    mem_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            base_q      <= '0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_inst_q   <= 32'd0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            if_inst_q   <= if_inst_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ram_a_o     = ram_a_q;
    assign bus.ram_dout_o  = ram_dout_q;
    assign bus.ram_wr_o    = ram_wr_q;
    assign bus.if_done_o   = if_done_q;
    assign bus.if_inst_o   = if_inst_q;
    assign bus.mem_done_o  = mem_done_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a transaction-level model
// and a byte-wide RAM model; checks every output on every cycle.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   started = 1'b0;

    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM: writes on the edge, read data registered one cycle after address.
    logic [7:0] ram [logic [31:0]];
    logic [7:0] mmem [logic [31:0]];

    function automatic logic [7:0] rd_ram(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rd_mm(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (bus.ram_wr_o) ram[bus.ram_a_o] = bus.ram_dout_o;
        bus.ram_din_i <= rd_ram(bus.ram_a_o);
    end

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram[a]  = d;
        mmem[a] = d;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timeout at %0t", nm, $time);
    endtask

    // Transaction-level model: elapsed edges since accept decide outputs.
    bit          m_act;
    int          m_kind;  // 0 fetch, 1 load, 2 store
    logic [31:0] m_base, m_wdata;
    int          m_n, m_t;
    bit          m_blk;
    logic [31:0] e_a, e_inst, e_rdata;
    logic [7:0]  e_dout;
    logic        e_wr, e_ifd, e_md, e_busy;

    function automatic logic [31:0] mread(input logic [31:0] b,
                                          input int n);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < n; i++)
            r = r + (32'(rd_mm(b + 32'(i))) << (8 * i));
        return r;
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_act = 0; e_a = 0; e_inst = 0; e_rdata = 0;
            e_dout = 0; e_wr = 0; e_ifd = 0; e_md = 0; e_busy = 0;
        end else begin
            m_blk = e_ifd || e_md;
            e_ifd = 0; e_md = 0; e_wr = 0;
            if (m_act) begin
                m_t++;
                if (m_kind == 0 && bus.if_flush_i) begin
                    m_act = 0;
                end else if (m_kind == 2) begin
                    if (m_t < m_n) begin
                        e_a    = m_base + 32'(m_t);
                        e_dout = m_wdata[8*m_t +: 8];
                        e_wr   = 1;
                        mmem[e_a] = e_dout;
                    end else begin
                        e_md  = 1;
                        m_act = 0;
                    end
                end else begin
                    if (m_t < m_n) e_a = m_base + 32'(m_t);
                    if (m_t == m_n + 1) begin
                        if (m_kind == 0) begin
                            e_inst = mread(m_base, m_n);
                            e_ifd  = 1;
                        end else begin
                            e_rdata = mread(m_base, m_n);
                            e_md    = 1;
                        end
                        m_act = 0;
                    end
                end
            end else if (!m_blk) begin
                if (bus.mem_req_i) begin
                    m_act   = 1;
                    m_t     = 0;
                    m_kind  = bus.mem_we_i ? 2 : 1;
                    m_n     = (bus.mem_len_i == 0) ? 1 :
                              (bus.mem_len_i == 1) ? 2 : 4;
                    m_base  = bus.mem_addr_i;
                    m_wdata = bus.mem_wdata_i;
                    e_a     = m_base;
                    if (bus.mem_we_i) begin
                        e_wr   = 1;
                        e_dout = m_wdata[7:0];
                        mmem[e_a] = e_dout;
                    end
                end else if (bus.if_req_i && !bus.if_flush_i) begin
                    m_act  = 1;
                    m_t    = 0;
                    m_kind = 0;
                    m_n    = 4;
                    m_base = bus.if_addr_i;
                    e_a    = m_base;
                end
            end
            e_busy = m_act;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ram_a", bus.ram_a_o, e_a);
            chk("ram_wr", 32'(bus.ram_wr_o), 32'(e_wr));
            chk("ram_dout", 32'(bus.ram_dout_o), 32'(e_dout));
            chk("if_done", 32'(bus.if_done_o), 32'(e_ifd));
            chk("if_inst", bus.if_inst_o, e_inst);
            chk("mem_done", 32'(bus.mem_done_o), 32'(e_md));
            chk("mem_rdata", bus.mem_rdata_o, e_rdata);
            chk("busy", 32'(bus.busy_o), 32'(e_busy));
        end
    end

    logic [31:0] a_log [$];

    task automatic do_fetch(input logic [31:0] a, output logic [31:0] d,
                            output int cyc);
        bus.if_addr_i = a;
        bus.if_req_i  = 1'b1;
        cyc = 0;
        d   = 32'd0;
        a_log.delete();
        do begin
            @(negedge clk);
            cyc++;
            a_log.push_back(bus.ram_a_o);
        end while (!bus.if_done_o && cyc < 60);
        if (!bus.if_done_o) fail("fetch_wait");
        d = bus.if_inst_o;
        bus.if_req_i = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [31:0] a,
                          input logic [1:0] len, input logic [31:0] wd,
                          output logic [31:0] d, output int cyc);
        bus.mem_we_i    = we;
        bus.mem_addr_i  = a;
        bus.mem_len_i   = len;
        bus.mem_wdata_i = wd;
        bus.mem_req_i   = 1'b1;
        cyc = 0;
        d   = 32'd0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.mem_done_o && cyc < 60);
        if (!bus.mem_done_o) fail("mem_wait");
        d = bus.mem_rdata_o;
        bus.mem_req_i = 1'b0;
    endtask

    logic [31:0] d0, d1;
    int          c0, c1;

    initial begin
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_flush_i = 0;
        bus.mem_req_i = 0; bus.mem_we_i = 0; bus.mem_addr_i = 0;
        bus.mem_len_i = 0; bus.mem_wdata_i = 0;
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h10); preload(32'h103, 8'h00);
        preload(32'h200, 8'h78); preload(32'h201, 8'h56);
        preload(32'h202, 8'h34); preload(32'h203, 8'h12);
        preload(32'hFFFF_FFFE, 8'hAA); preload(32'hFFFF_FFFF, 8'hBB);
        preload(32'h0, 8'hCC);         preload(32'h1, 8'hDD);

        repeat (3) @(negedge clk);
        chk("rst_ram_a", bus.ram_a_o, 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_inst", bus.if_inst_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_fetch(32'h100, d0, c0);
        chk("fetch_data", d0, 32'h0010_0513);
        chk("fetch_lat", 32'(c0), 32'd6);
        chk("fetch_a0", a_log[0], 32'h100);
        chk("fetch_a3", a_log[3], 32'h103);
        @(negedge clk);

        do_mem(1'b1, 32'h2000, 2'b10, 32'hDEAD_BEEF, d0, c0);
        chk("store_lat", 32'(c0), 32'd5);
        chk("store_b0", 32'(rd_ram(32'h2000)), 32'hEF);
        chk("store_b1", 32'(rd_ram(32'h2001)), 32'hBE);
        chk("store_b3", 32'(rd_ram(32'h2003)), 32'hDE);
        @(negedge clk);

        do_mem(1'b0, 32'h2003, 2'b00, 32'd0, d0, c0);
        chk("ldb_data", d0, 32'h0000_00DE);
        chk("ldb_lat", 32'(c0), 32'd3);
        @(negedge clk);
        do_mem(1'b0, 32'h2002, 2'b01, 32'd0, d0, c0);
        chk("ldh_data", d0, 32'h0000_DEAD);
        @(negedge clk);
        do_mem(1'b0, 32'hFFFF_FFFE, 2'b11, 32'd0, d0, c0);
        chk("wrap_data", d0, 32'hDDCC_BBAA);
        chk("wrap_lat", 32'(c0), 32'd6);
        @(negedge clk);

        fork
            do_mem(1'b0, 32'h2000, 2'b00, 32'd0, d0, c0);
            do_fetch(32'h100, d1, c1);
        join
        chk("cont_mem", d0, 32'h0000_00EF);
        chk("cont_mem_lat", 32'(c0), 32'd3);
        chk("cont_if", d1, 32'h0010_0513);
        chk("cont_if_lat", 32'(c1), 32'd10);
        @(negedge clk);

        bus.if_req_i = 1'b1; bus.if_flush_i = 1'b1; bus.if_addr_i = 32'h200;
        repeat (2) @(negedge clk);
        chk("flush_idle_blk", 32'(bus.busy_o), 32'd0);
        bus.if_flush_i = 1'b0; bus.if_addr_i = 32'h180;
        repeat (3) @(negedge clk);
        chk("flush_pre_a", bus.ram_a_o, 32'h182);
        bus.if_flush_i = 1'b1; bus.if_req_i = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(bus.busy_o), 32'd0);
        bus.if_flush_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("flush_nodone", 32'(bus.if_done_o), 32'd0);
        end
        do_fetch(32'h200, d0, c0);
        chk("post_flush", d0, 32'h1234_5678);
        chk("post_flush_lat", 32'(c0), 32'd6);
        @(negedge clk);

        bus.mem_we_i = 1'b1; bus.mem_addr_i = 32'h3000;
        bus.mem_len_i = 2'b10; bus.mem_wdata_i = 32'h1122_3344;
        bus.mem_req_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_st_a", bus.ram_a_o, 32'h3001);
        chk("rst_st_wr", 32'(bus.ram_wr_o), 32'd1);
        rst = 1'b1; bus.mem_req_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_wr", 32'(bus.ram_wr_o), 32'd0);
        chk("rst_mid_a", bus.ram_a_o, 32'd0);
        chk("rst_mid_rdata", bus.mem_rdata_o, 32'd0);
        chk("rst_mid_dout", 32'(bus.ram_dout_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        do_fetch(32'h100, d0, c0);
        chk("post_rst_fetch", d0, 32'h0010_0513);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
